// File: rtl/noc_pkg.sv
// Shared NoC router definitions: output-port codes, flit types, allocator state
// and the op-code/index conversion helpers.
package noc_pkg;

  typedef enum logic [2:0] {
    PORT_NONE  = 3'b000,
    PORT_LOCAL = 3'b001,
    PORT_EAST  = 3'b010,
    PORT_WEST  = 3'b011,
    PORT_NORTH = 3'b100,
    PORT_SOUTH = 3'b101
  } port_t;

  typedef enum logic [1:0] {
    FT_NONE = 2'b00,
    FT_TAIL = 2'b01,
    FT_BODY = 2'b10,
    FT_HEAD = 2'b11
  } flit_t;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op >= PORT_LOCAL) && (op <= PORT_SOUTH);
  endfunction

  // Op code k selects output index k-1.
  function automatic logic [2:0] op2idx(input logic [2:0] op);
    return op - 3'd1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// scanning cyclically; returns a one-hot grant and the winning index.
module rr_arb #(
  parameter int NP = 5,
  parameter int SW = 3
) (
  input  logic [NP-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic [NP-1:0] gnt,
  output logic [SW-1:0] idx
);

  localparam int AW = SW + 1;

  logic [AW-1:0] sum;
  logic [SW-1:0] pos;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      sum = {1'b0, ptr} + AW'(k);
      if (sum >= AW'(NP)) sum = sum - AW'(NP);
      pos = sum[SW-1:0];
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/sw_alloc_rr.sv
// Wormhole switch allocator: each output is arbitrated round-robin among header
// requests and stays locked to the winning input from header to tail.
module sw_alloc_rr
  import noc_pkg::*;
#(
  parameter int NP = 5,
  parameter int SW = 3
) (
  input  logic             clk_t,
  input  logic             rst_t,
  input  logic [NP-1:0]    in_valid,
  input  logic [2*NP-1:0]  in_type,
  input  logic [SW*NP-1:0] in_op,
  input  logic [NP-1:0]    out_ready,
  output logic [NP-1:0]    in_grant,
  output logic [NP-1:0]    out_valid,
  output logic [SW*NP-1:0] out_sel,
  output logic [NP-1:0]    out_busy,
  output logic             route_err
);

  out_state_t    state   [NP];
  logic [SW-1:0] owner   [NP];
  logic [SW-1:0] rr_ptr  [NP];
  logic [NP-1:0] req     [NP];
  logic [NP-1:0] arb_gnt [NP];
  logic [SW-1:0] arb_idx [NP];
  logic [NP-1:0] xfer;
  logic [NP-1:0] tail_xfer;
  logic          bad_hdr;
  logic          own_valid;
  logic [1:0]    own_type;

  // Only legal headers request; illegal ones just raise the error pulse.
  always_comb begin
    bad_hdr = 1'b0;
    for (int unsigned o = 0; o < NP; o++) req[o] = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (in_valid[i] && in_type[2*i +: 2] == FT_HEAD) begin
        if (!op_legal(in_op[SW*i +: SW])) begin
          bad_hdr = 1'b1;
        end else begin
          for (int unsigned o = 0; o < NP; o++)
            if (op2idx(in_op[SW*i +: SW]) == SW'(o)) req[o][i] = 1'b1;
        end
      end
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_arb
    rr_arb #(.NP(NP), .SW(SW)) u_arb (
      .req (req[o]),
      .ptr (rr_ptr[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o])
    );
  end

  always_comb begin
    xfer      = '0;
    tail_xfer = '0;
    in_grant  = '0;
    out_sel   = '0;
    out_busy  = '0;
    own_valid = 1'b0;
    own_type  = FT_NONE;
    for (int unsigned o = 0; o < NP; o++) begin
      own_valid = 1'b0;
      own_type  = FT_NONE;
      for (int unsigned i = 0; i < NP; i++) begin
        if (owner[o] == SW'(i)) begin
          own_valid = in_valid[i];
          own_type  = in_type[2*i +: 2];
        end
      end
      out_sel[SW*o +: SW] = owner[o];
      out_busy[o]         = (state[o] == OUT_LOCKED);
      if (state[o] == OUT_LOCKED && own_valid && own_type != FT_NONE && out_ready[o]) begin
        xfer[o]      = 1'b1;
        tail_xfer[o] = (own_type == FT_TAIL);
        for (int unsigned i = 0; i < NP; i++)
          if (owner[o] == SW'(i)) in_grant[i] = 1'b1;
      end
    end
  end

  assign out_valid = xfer;

  always_ff @(posedge clk_t or negedge rst_t) begin
    if (!rst_t) begin
      for (int unsigned o = 0; o < NP; o++) begin
        state[o]  <= OUT_IDLE;
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
      end
      route_err <= 1'b0;
    end else begin
      route_err <= bad_hdr;
      for (int unsigned o = 0; o < NP; o++) begin
        case (state[o])
          OUT_IDLE: begin
            if (|arb_gnt[o]) begin
              state[o] <= OUT_LOCKED;
              owner[o] <= arb_idx[o];
            end
          end
          OUT_LOCKED: begin
            if (tail_xfer[o]) begin
              state[o]  <= OUT_IDLE;
              rr_ptr[o] <= (owner[o] == SW'(NP-1)) ? '0 : owner[o] + 1'b1;
            end
          end
          default: state[o] <= OUT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sw_alloc_rr.sv
// Bench for sw_alloc_rr: directed scenarios plus randomized packet traffic,
// all compared against a packet-level reference model of the allocator.
module tb_sw_alloc_rr;

  localparam int NP = 5;
  localparam int SW = 3;

  logic             clk_t = 1'b0;
  logic             rst_t;
  logic [NP-1:0]    in_valid, out_ready, in_grant, out_valid, out_busy;
  logic [2*NP-1:0]  in_type;
  logic [SW*NP-1:0] in_op, out_sel;
  logic             route_err;

  sw_alloc_rr #(.NP(NP), .SW(SW)) dut (
    .clk_t     (clk_t),
    .rst_t     (rst_t),
    .in_valid  (in_valid),
    .in_type   (in_type),
    .in_op     (in_op),
    .out_ready (out_ready),
    .in_grant  (in_grant),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_busy  (out_busy),
    .route_err (route_err)
  );

  always #5 clk_t = ~clk_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Per-input flit queues; a flit is (type << 3) | op.
  int fq [NP][$];
  bit m_lock [NP];
  int m_own  [NP];
  int m_ptr  [NP];
  bit m_err;

  logic [NP-1:0]    e_grant, e_valid, e_busy;
  logic [SW*NP-1:0] e_sel;
  logic [NP-1:0]    s_grant, s_valid, s_busy;
  logic [SW*NP-1:0] s_sel;
  logic             s_err;
  logic [NP-1:0]    vmask;
  bit               bubbles;
  int               seen [$];
  int               exp3 [9] = '{0, 0, 0, 2, 2, 2, 4, 4, 4};
  int               exp4 [4] = '{0, 0, 4, 4};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ftype(input int i);
    return int'(in_type[2*i +: 2]);
  endfunction

  function automatic int fop(input int i);
    return int'(in_op[3*i +: 3]);
  endfunction

  function automatic bit is_bad_hdr(input int i);
    return in_valid[i] && ftype(i) == 3 && (fop(i) < 1 || fop(i) > 5);
  endfunction

  task automatic push_pkt(input int i, input logic [2:0] op, input int nbody);
    fq[i].push_back((3 << 3) | int'(op));
    if (op >= 3'd1 && op <= 3'd5) begin
      for (int b = 0; b < nbody; b++) fq[i].push_back((2 << 3) | int'(op));
      fq[i].push_back((1 << 3) | int'(op));
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_lock[o] = 1'b0;
      m_own[o]  = 0;
      m_ptr[o]  = 0;
      fq[o].delete();
    end
    m_err = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      in_valid[i]      = 1'b0;
      in_type[2*i +: 2] = 2'b00;
      in_op[3*i +: 3]   = 3'b000;
      if (fq[i].size() > 0 && vmask[i]) begin
        in_valid[i] = 1'b1;
        if (!(bubbles && $urandom_range(0, 15) == 0)) begin
          in_type[2*i +: 2] = 2'(fq[i][0] >> 3);
          in_op[3*i +: 3]   = 3'(fq[i][0] & 7);
        end
      end
    end
  endtask

  task automatic model_comb();
    int w;
    e_grant = '0;
    e_valid = '0;
    e_busy  = '0;
    e_sel   = '0;
    for (int o = 0; o < NP; o++) begin
      w = m_own[o];
      e_busy[o]      = m_lock[o];
      e_sel[3*o +: 3] = 3'(w);
      if (m_lock[o] && in_valid[w] && ftype(w) != 0 && out_ready[o]) begin
        e_valid[o] = 1'b1;
        e_grant[w] = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    int i;
    m_err = 1'b0;
    for (int k = 0; k < NP; k++) if (is_bad_hdr(k)) m_err = 1'b1;
    for (int o = 0; o < NP; o++) begin
      if (m_lock[o]) begin
        if (e_valid[o] && ftype(m_own[o]) == 1) begin
          m_lock[o] = 1'b0;
          m_ptr[o]  = (m_own[o] + 1) % NP;
        end
      end else begin
        for (int k = 0; k < NP; k++) begin
          i = (m_ptr[o] + k) % NP;
          if (!m_lock[o] && in_valid[i] && ftype(i) == 3 && fop(i) == o + 1) begin
            m_lock[o] = 1'b1;
            m_own[o]  = i;
          end
        end
      end
    end
    for (int k = 0; k < NP; k++) begin
      if (fq[k].size() > 0 && (e_grant[k] || is_bad_hdr(k))) void'(fq[k].pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk_t);
    drive();
    #2;
    model_comb();
    s_grant = in_grant;
    s_valid = out_valid;
    s_busy  = out_busy;
    s_sel   = out_sel;
    s_err   = route_err;
    check_eq("grant", in_grant, e_grant);
    check_eq("out_valid", out_valid, e_valid);
    check_eq("out_busy", out_busy, e_busy);
    check_eq("out_sel", out_sel, e_sel);
    check_eq("route_err", route_err, m_err);
    @(posedge clk_t);
    #1;
    model_update();
  endtask

  task automatic run_collect(input int o, input int limit);
    seen.delete();
    for (int c = 0; c < limit; c++) begin
      step();
      if (s_valid[o]) seen.push_back(int'(s_sel[3*o +: 3]));
    end
  endtask

  initial begin
    int bad;
    rst_t = 1'b0;
    in_valid = '0;
    in_type = '0;
    in_op = '0;
    out_ready = '1;
    vmask = '1;
    bubbles = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_t);
    #1;
    check_eq("rst_busy", out_busy, 0);
    check_eq("rst_grant", in_grant, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_sel", out_sel, 0);
    check_eq("rst_err", route_err, 0);
    @(negedge clk_t);
    rst_t = 1'b1;

    // Reset in the middle of a packet on E
    push_pkt(0, 3'b010, 3);
    repeat (3) step();
    check_eq("t1_locked", s_busy[1], 1);
    @(negedge clk_t);
    drive();
    #2;
    rst_t = 1'b0;
    #1;
    check_eq("t1_busy", out_busy, 0);
    check_eq("t1_grant", in_grant, 0);
    check_eq("t1_valid", out_valid, 0);
    model_reset();
    drive();
    @(negedge clk_t);
    rst_t = 1'b1;
    #1;
    check_eq("t1_idle", out_busy, 0);

    // Single packet to L from input 1
    push_pkt(1, 3'b001, 2);
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("t2_grant", s_grant[1], (c >= 1 && c <= 4) ? 1 : 0);
      if (c == 1) check_eq("t2_sel", s_sel[2:0], 1);
      if (c == 5) check_eq("t2_busy", s_busy[0], 0);
    end

    // Three-way contention on N
    push_pkt(0, 3'b100, 1);
    push_pkt(2, 3'b100, 1);
    push_pkt(4, 3'b100, 1);
    run_collect(3, 20);
    check_eq("t3_count", seen.size(), 9);
    for (int k = 0; k < 9 && k < seen.size(); k++) check_eq("t3_order", seen[k], exp3[k]);

    // Pointer wraps from 4 back to 0
    push_pkt(0, 3'b100, 0);
    push_pkt(4, 3'b100, 0);
    run_collect(3, 12);
    check_eq("t4_count", seen.size(), 4);
    for (int k = 0; k < 4 && k < seen.size(); k++) check_eq("t4_order", seen[k], exp4[k]);

    // Backpressure on S mid-packet
    push_pkt(2, 3'b101, 3);
    repeat (3) step();
    out_ready[4] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("t5_grant", s_grant, 0);
      check_eq("t5_busy", s_busy[4], 1);
    end
    out_ready[4] = 1'b1;
    run_collect(4, 20);
    check_eq("t5_rest", seen.size(), 3);
    for (int k = 0; k < seen.size(); k++) check_eq("t5_owner", seen[k], 2);

    // Parallel grants on E and W, plus an illegal header
    push_pkt(0, 3'b010, 0);
    push_pkt(1, 3'b011, 0);
    push_pkt(3, 3'b111, 0);
    step();
    check_eq("t6_grant0", s_grant, 0);
    step();
    check_eq("t6_grant1", s_grant, 5'b00011);
    check_eq("t6_err", s_err, 1);
    step();
    check_eq("t6_err_clr", s_err, 0);
    repeat (2) step();

    // Randomized traffic with bubbles, stalls and one asynchronous reset
    bubbles = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        @(negedge clk_t);
        #2;
        rst_t = 1'b0;
        #1;
        check_eq("rnd_rst_busy", out_busy, 0);
        check_eq("rnd_rst_grant", in_grant, 0);
        model_reset();
        drive();
        @(negedge clk_t);
        rst_t = 1'b1;
      end
      for (int i = 0; i < NP; i++) begin
        if (fq[i].size() < 2 && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 9) == 0) begin
            bad = int'($urandom_range(0, 2));
            push_pkt(i, (bad == 0) ? 3'd0 : 3'(bad + 5), 0);
          end else begin
            push_pkt(i, 3'($urandom_range(1, 5)), int'($urandom_range(0, 3)));
          end
        end
        vmask[i]     = ($urandom_range(0, 7) != 0);
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
